// File: rtl/mld_pkg.sv
// Shared types and defaults for the cyclic majority-logic decoder family.
package mld_pkg;

  localparam int unsigned N_DEFAULT     = 7;
  localparam int unsigned CNT_W_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_CORRECT = 2'd2,
    ST_UNLOAD  = 2'd3
  } mld_state_e;

endpackage

// File: rtl/mld_codeword_buffer_if.sv
// Handshake and data bundle between a codeword source/majority gates and the buffer.
interface mld_codeword_buffer_if #(
  parameter int unsigned N = mld_pkg::N_DEFAULT
);

  logic         start;
  logic         in_valid;
  logic         in_bit;
  logic         corr;
  logic [N-1:0] taps;
  logic         out_bit;
  logic         out_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, in_valid, in_bit, corr,
    input  taps, out_bit, out_valid, busy, done
  );

  modport slave (
    input  start, in_valid, in_bit, corr,
    output taps, out_bit, out_valid, busy, done
  );

endinterface

// File: rtl/mld_bit_counter.sv
// Phase bit counter; terminal marks the last beat (count N-1) of each busy phase.
module mld_bit_counter #(
  parameter int unsigned N     = 7,
  parameter int unsigned CNT_W = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign terminal = (cnt_q == LAST);

endmodule

// File: rtl/mld_codeword_buffer.sv
// N-bit codeword buffer: serial load, N-cycle corrected rotation, serial unload.
module mld_codeword_buffer
  import mld_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  mld_codeword_buffer_if.slave    bus
);

  mld_state_e   state_q, state_nxt;
  logic [N-1:0] cells_q, cells_nxt;
  logic         done_q, done_nxt;
  logic         busy_q;
  logic         out_valid_q;
  logic         cnt_clr;
  logic         cnt_en;
  logic         cnt_last;

  mld_bit_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clr),
    .enable   (cnt_en),
    .terminal (cnt_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Phase sequencing; the counter is cleared on every phase change so it never passes N-1.
  always_comb begin
    state_nxt = state_q;
    cells_nxt = cells_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    done_nxt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (bus.start) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.in_valid) begin
          cells_nxt = {cells_q[N-2:0], bus.in_bit};
          if (cnt_last) begin
            cnt_clr   = 1'b1;
            state_nxt = ST_CORRECT;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_CORRECT: begin
        // The correction lands on the bit wrapping from the output end back to cell 0.
        cells_nxt = {cells_q[N-2:0], cells_q[N-1] ^ bus.corr};
        if (cnt_last) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_UNLOAD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_UNLOAD: begin
        cells_nxt = {cells_q[N-2:0], 1'b0};
        if (cnt_last) begin
          cnt_clr   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        cnt_clr   = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cells_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cells_q     <= cells_nxt;
      done_q      <= done_nxt;
      busy_q      <= (state_nxt != ST_IDLE);
      out_valid_q <= (state_nxt == ST_UNLOAD);
    end
  end

  assign bus.taps      = cells_q;
  assign bus.out_bit   = cells_q[N-1];
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mld_codeword_buffer.sv
// Scoreboard bench: driver predicts the corrected word, monitor checks the serial output.
module tb_mld_codeword_buffer;

  localparam int unsigned N     = 7;
  localparam int unsigned CNT_W = 3;

  logic clk;
  logic reset;

  mld_codeword_buffer_if #(.N(N)) bus ();

  mld_codeword_buffer #(
    .N     (N),
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec;
  int   n_err;
  int   dones_seen;
  int   dones_exp;
  bit   exp_q[$];
  logic prev_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one predicted bit per valid output beat, and checks done framing.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          check("out_bit", 32'(bus.out_bit), 32'(exp_q.pop_front()));
        end
      end
      if (bus.done) begin
        dones_seen++;
        check("done_drain", 32'(exp_q.size()), 32'd0);
        check("done_single", 32'(prev_done), 32'd0);
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Runs one word from IDLE (or the done cycle). dv[N-1] is the first received bit;
  // cv[N-1-k] is the correction offered on CORRECT cycle k. abort_at < N resets mid-CORRECT.
  task automatic run_word(input logic [N-1:0] dv, input logic [N-1:0] cv, input int vmode,
                          input bit noise, input int abort_at);
    int   accepted;
    int   guard;
    int   cyc;
    logic v;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    accepted = 0;
    guard    = 0;
    v        = 1'b1;
    while (accepted < int'(N) && guard < 40 * int'(N)) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = 1'($urandom);
      endcase
      bus.in_valid = v;
      bus.in_bit   = v ? dv[N-1-accepted] : 1'($urandom);
      @(posedge clk); #1;
      if (v) accepted++;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    check("load_beats", 32'(accepted), 32'(N));
    check("taps_at_correct", 32'(bus.taps), 32'(dv));
    check("busy_in_correct", 32'(bus.busy), 32'd1);
    check("no_out_in_correct", 32'(bus.out_valid), 32'd0);
    // Reference: the k-th received bit leaves corrected by the k-th correction, in order.
    for (int k = 0; k < int'(N); k++) exp_q.push_back(dv[N-1-k] ^ cv[N-1-k]);
    for (int k = 0; k < int'(N); k++) begin
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        check("rst_taps", 32'(bus.taps), 32'd0);
        check("rst_out_bit", 32'(bus.out_bit), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        exp_q.delete();
        bus.corr  = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        return;
      end
      bus.corr  = cv[N-1-k];
      bus.start = noise ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
    end
    bus.corr = 1'b0;
    check("unload_valid", 32'(bus.out_valid), 32'd1);
    cyc = 0;
    while (!bus.done && cyc < 3 * int'(N)) begin
      bus.start = noise ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    check("done_latency", 32'(cyc), 32'(N));
    check("done_seen", 32'(bus.done), 32'd1);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("taps_cleared", 32'(bus.taps), 32'd0);
    dones_exp++;
  endtask

  task automatic idle_gap();
    @(posedge clk); #1;
    check("gap_done_low", 32'(bus.done), 32'd0);
    check("gap_busy_low", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; dones_seen = 0; dones_exp = 0; prev_done = 1'b0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.corr     = 1'b0;
    #2;
    check("reset_taps", 32'(bus.taps), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_word(7'b1011000, 7'b0000000, 0, 1'b0, N);   // plain pass-through
    idle_gap();
    run_word(7'b1011000, 7'b1000000, 0, 1'b0, N);   // first bit corrected
    idle_gap();
    run_word(7'(($urandom)), 7'b0000000, 1, 1'b0, N);  // alternating in_valid
    idle_gap();
    run_word(7'b0110101, 7'b0010010, 0, 1'b1, N);   // start noise while busy
    idle_gap();
    run_word(7'b1111111, 7'b0000000, 0, 1'b0, 3);   // reset mid-CORRECT
    run_word(7'b0100110, 7'b0000001, 0, 1'b0, N);   // clean word after abort
    run_word(7'b1100011, 7'b0101000, 0, 1'b0, N);   // back-to-back from done cycle
    idle_gap();

    for (int w = 0; w < 24; w++) begin
      logic [N-1:0] dv;
      logic [N-1:0] cv;
      dv = 7'($urandom);
      cv = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'(1 << $urandom_range(0, N - 1));
      run_word(dv, cv, $urandom_range(0, 2), 1'($urandom), N);
      if ($urandom_range(0, 1) == 0) idle_gap();
    end

    idle_gap();
    repeat (3) @(posedge clk);
    #1;
    check("done_count", 32'(dones_seen), 32'(dones_exp));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
